// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the data-memory access sequencer.
// Size codes, FSM state encoding and byte-lane helpers.
package mips_mem_pkg;

   localparam logic [1:0] DS_WORD = 2'b00;
   localparam logic [1:0] DS_HALF = 2'b01;
   localparam logic [1:0] DS_BYTE = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic [3:0]  be;
      logic [31:0] wdata;
   } lanes_t;

   // Byte enables and lane-replicated store data for one access.
   function automatic lanes_t bus_lanes(
      input logic [1:0]  ds,
      input logic [1:0]  a,
      input logic [31:0] wd
   );
      lanes_t l;
      l.be    = 4'b1111;
      l.wdata = wd;
      case (ds)
         DS_BYTE: begin
            l.be    = 4'b0001 << a;
            l.wdata = {4{wd[7:0]}};
         end
         DS_HALF: begin
            l.be    = a[1] ? 4'b1100 : 4'b0011;
            l.wdata = {2{wd[15:0]}};
         end
         default: ;
      endcase
      return l;
   endfunction

   // Accesses that must be rejected rather than issued.
   function automatic logic misaligned(
      input logic [1:0] ds,
      input logic [1:0] a
   );
      return (ds == 2'b11) ||
             ((ds == DS_WORD) && (a != 2'b00)) ||
             ((ds == DS_HALF) && a[0]);
   endfunction

endpackage

// File: rtl/load_align.sv
// Load-data lane select and sign/zero extension.
// Purely combinational.
module load_align
   import mips_mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  a,
   input  logic [1:0]  ds,
   input  logic        btx,
   output logic [31:0] ext
);

   logic [31:0] sh;

   // Shift the addressed lane down to bit 0, then extend by size.
   always_comb begin
      sh  = word >> {a, 3'b000};
      ext = word;
      case (ds)
         DS_BYTE: ext = {{24{btx & sh[7]}}, sh[7:0]};
         DS_HALF: ext = {{16{btx & sh[15]}}, sh[15:0]};
         default: ext = word;
      endcase
   end

endmodule

// File: rtl/mem_access_seq.sv
// Multicycle data-memory access sequencer: IDLE -> BUS -> DONE.
// Optional bus abort counter enabled by defining MEM_TIMEOUT_EN.
module mem_access_seq
   import mips_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [1:0]  dS,
   input  logic        btX,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        misalign,
   output logic        timeout,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  ds_q, ds_d;
   logic        btx_q, btx_d;
   logic        we_q, we_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        misalign_q, misalign_d;
   logic        aborted;
   logic        in_bus;
   logic        access;
   logic [31:0] ld_ext;
   lanes_t      lanes;

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
   logic [7:0] cnt_q, cnt_d;
   logic       ab_q, ab_d;
   assign aborted = ab_q;
`else
   assign aborted = 1'b0;
`endif

   assign access = memread | memwrite;
   assign in_bus = (state_q == S_BUS);
   assign lanes  = bus_lanes(ds_q, addr_q[1:0], wdata_q);

   load_align u_align (
      .word (bus_rdata),
      .a    (addr_q[1:0]),
      .ds   (ds_q),
      .btx  (btx_q),
      .ext  (ld_ext)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      ds_d       = ds_q;
      btx_d      = btx_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      misalign_d = 1'b0;
      stall      = 1'b0;
`ifdef MEM_TIMEOUT_EN
      ab_d       = ab_q;
      cnt_d      = in_bus ? cnt_q + 8'd1 : 8'd0;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (access) begin
               if (misaligned(dS, addr[1:0])) begin
                  misalign_d = 1'b1;
               end else begin
                  stall   = 1'b1;
                  addr_d  = addr;
                  ds_d    = dS;
                  btx_d   = btX;
                  we_d    = memwrite;
                  wdata_d = wdata;
`ifdef MEM_TIMEOUT_EN
                  ab_d    = 1'b0;
`endif
                  state_d = S_BUS;
               end
            end
         end
         S_BUS: begin
            stall = 1'b1;
            if (bus_ack) begin
               if (!we_q) rdata_d = ld_ext;
               state_d = S_DONE;
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               ab_d    = 1'b1;
               state_d = S_DONE;
            end
`endif
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         ds_q       <= '0;
         btx_q      <= 1'b0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         ds_q       <= ds_d;
         btx_q      <= btx_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         misalign_q <= misalign_d;
      end
   end

`ifdef MEM_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         ab_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ab_q  <= ab_d;
      end
   end
`endif

   assign rdata       = rdata_q;
   assign misalign    = misalign_q;
   assign rdata_valid = (state_q == S_DONE) && !we_q && !aborted;
   assign timeout     = (state_q == S_DONE) && aborted;
   assign bus_req     = in_bus;
   assign bus_we      = in_bus && we_q;
   assign bus_addr    = in_bus ? {addr_q[31:2], 2'b00} : 32'd0;
   assign bus_be      = in_bus ? lanes.be : 4'd0;
   assign bus_wdata   = (in_bus && we_q) ? lanes.wdata : 32'd0;

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed self-checking bench for mem_access_seq.
// Timeout scenario runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        memread, memwrite, btX, bus_ack;
   logic [1:0]  dS;
   logic [31:0] addr, wdata, bus_rdata;
   logic        stall, rdata_valid, misalign, timeout;
   logic        bus_req, bus_we;
   logic [31:0] rdata, bus_addr, bus_wdata;
   logic [3:0]  bus_be;

   int n_chk = 0;
   int n_fail = 0;
   int stall_cnt = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (stall === 1'b1) stall_cnt <= stall_cnt + 1;

   mem_access_seq #(.TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n), .memread(memread), .memwrite(memwrite),
      .dS(dS), .btX(btX), .addr(addr), .wdata(wdata), .stall(stall),
      .rdata(rdata), .rdata_valid(rdata_valid), .misalign(misalign),
      .timeout(timeout), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic outs_zero(input string tag);
      chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
      chk({tag, "_rdata"}, rdata, 32'd0);
      chk({tag, "_rvalid"}, {31'd0, rdata_valid}, 32'd0);
      chk({tag, "_misalign"}, {31'd0, misalign}, 32'd0);
      chk({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
      chk({tag, "_req"}, {31'd0, bus_req}, 32'd0);
      chk({tag, "_we"}, {31'd0, bus_we}, 32'd0);
      chk({tag, "_addr"}, bus_addr, 32'd0);
      chk({tag, "_be"}, {28'd0, bus_be}, 32'd0);
      chk({tag, "_wdata"}, bus_wdata, 32'd0);
   endtask

   task automatic txn(input string tag, input logic wr, input logic [1:0] ds,
                      input logic bx, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd,
                      input int n_bus, input logic [3:0] exp_be,
                      input logic [31:0] exp_wd);
      int s0;
      memread = !wr; memwrite = wr; dS = ds; btX = bx;
      addr = a; wdata = wd;
      #1;
      chk({tag, "_stall_req_cycle"}, {31'd0, stall}, 32'd1);
      s0 = stall_cnt;
      step();
      chk({tag, "_req"}, {31'd0, bus_req}, 32'd1);
      chk({tag, "_we"}, {31'd0, bus_we}, {31'd0, wr});
      chk({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
      chk({tag, "_be"}, {28'd0, bus_be}, {28'd0, exp_be});
      if (wr) chk({tag, "_wdata"}, bus_wdata, exp_wd);
      for (int i = 1; i <= n_bus; i++) begin
         if (i == n_bus) begin
            bus_ack = 1'b1;
            bus_rdata = rd;
         end
         step();
      end
      bus_ack = 1'b0;
      bus_rdata = 32'd0;
      chk({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
      chk({tag, "_done_req"}, {31'd0, bus_req}, 32'd0);
      chk({tag, "_stall_cycles"}, stall_cnt - s0, n_bus + 1);
   endtask

   task automatic release_req();
      memread = 1'b0;
      memwrite = 1'b0;
      step();
   endtask

   task automatic miss(input string tag, input logic [1:0] ds,
                       input logic [31:0] a);
      memread = 1'b1; dS = ds; addr = a;
      #1;
      chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
      step();
      memread = 1'b0;
      chk({tag, "_pulse"}, {31'd0, misalign}, 32'd1);
      chk({tag, "_req"}, {31'd0, bus_req}, 32'd0);
      chk({tag, "_stall2"}, {31'd0, stall}, 32'd0);
      step();
      chk({tag, "_pulse_end"}, {31'd0, misalign}, 32'd0);
      chk({tag, "_req2"}, {31'd0, bus_req}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; memread = 1'b0; memwrite = 1'b0; dS = 2'b00;
      btX = 1'b0; addr = 32'd0; wdata = 32'd0;
      bus_ack = 1'b0; bus_rdata = 32'd0;
      step();
      step();
      outs_zero("reset");
      rst_n = 1'b1;
      step();

      txn("lw", 1'b0, 2'b00, 1'b0, 32'h104, 32'd0, 32'hDEADBEEF, 3,
          4'b1111, 32'd0);
      chk("lw_rvalid", {31'd0, rdata_valid}, 32'd1);
      chk("lw_rdata", rdata, 32'hDEADBEEF);
      release_req();
      chk("lw_rvalid_end", {31'd0, rdata_valid}, 32'd0);
      chk("lw_rdata_hold", rdata, 32'hDEADBEEF);

      bus_ack = 1'b1; bus_rdata = 32'h11111111;
      step();
      bus_ack = 1'b0;
      chk("idle_ack_req", {31'd0, bus_req}, 32'd0);
      chk("idle_ack_rv", {31'd0, rdata_valid}, 32'd0);
      chk("idle_ack_rdata", rdata, 32'hDEADBEEF);
      step();

      txn("lb", 1'b0, 2'b10, 1'b1, 32'h103, 32'd0, 32'h80FF0000, 1,
          4'b1000, 32'd0);
      chk("lb_rvalid", {31'd0, rdata_valid}, 32'd1);
      chk("lb_rdata", rdata, 32'hFFFFFF80);
      release_req();
      txn("lbu", 1'b0, 2'b10, 1'b0, 32'h103, 32'd0, 32'h80FF0000, 1,
          4'b1000, 32'd0);
      chk("lbu_rdata", rdata, 32'h00000080);
      release_req();
      txn("lh", 1'b0, 2'b01, 1'b1, 32'h102, 32'd0, 32'h80FF0000, 2,
          4'b1100, 32'd0);
      chk("lh_rdata", rdata, 32'hFFFF80FF);
      release_req();

      txn("sh", 1'b1, 2'b01, 1'b0, 32'h102, 32'h1234ABCD, 32'h0, 1,
          4'b1100, 32'hABCDABCD);
      chk("sh_rvalid", {31'd0, rdata_valid}, 32'd0);
      chk("sh_rdata_hold", rdata, 32'hFFFF80FF);
      release_req();
      txn("sb", 1'b1, 2'b10, 1'b0, 32'h101, 32'h00000055, 32'h0, 2,
          4'b0010, 32'h55555555);
      chk("sb_rvalid", {31'd0, rdata_valid}, 32'd0);
      release_req();
      txn("sw", 1'b1, 2'b00, 1'b0, 32'h108, 32'hCAFEF00D, 32'h0, 1,
          4'b1111, 32'hCAFEF00D);
      release_req();

      miss("mis_lw", 2'b00, 32'h101);
      miss("mis_lh", 2'b01, 32'h103);
      miss("mis_ds11", 2'b11, 32'h100);
      chk("mis_rdata_hold", rdata, 32'hFFFF80FF);

      memread = 1'b1; memwrite = 1'b0; dS = 2'b00; addr = 32'h200;
      step();
      chk("rst_bus_req", {31'd0, bus_req}, 32'd1);
      rst_n = 1'b0; memread = 1'b0;
      #1;
      outs_zero("rst_mid");
      step();
      rst_n = 1'b1;
      step();
      txn("lw2", 1'b0, 2'b00, 1'b0, 32'h200, 32'd0, 32'h0BADF00D, 1,
          4'b1111, 32'd0);
      chk("lw2_rvalid", {31'd0, rdata_valid}, 32'd1);
      chk("lw2_rdata", rdata, 32'h0BADF00D);
      release_req();

`ifdef MEM_TIMEOUT_EN
      begin
         int nreq = 0;
         memread = 1'b1; dS = 2'b00; addr = 32'h300;
         step();
         for (int i = 0; i < 20 && timeout !== 1'b1; i++) begin
            if (bus_req === 1'b1) nreq++;
            step();
         end
         chk("to_pulse", {31'd0, timeout}, 32'd1);
         chk("to_req_cycles", nreq, 32'd8);
         chk("to_stall", {31'd0, stall}, 32'd0);
         chk("to_req", {31'd0, bus_req}, 32'd0);
         chk("to_rvalid", {31'd0, rdata_valid}, 32'd0);
         chk("to_rdata", rdata, 32'h0BADF00D);
         release_req();
         chk("to_pulse_end", {31'd0, timeout}, 32'd0);
      end
`else
      chk("no_timeout", {31'd0, timeout}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
